ex_muldiv: RTL and testbench

//  Iterative RV32M multiply/divide unit alongside the single-cycle ex stage; takes OP-opcode funct7=0000001 ops.
//  ex issues one op with start_i, holds the pipeline while busy_o=1, and takes result_o/rd on the done_o pulse.

---
 rtl/ex_muldiv_pkg.sv | 37 +++
 rtl/ex_muldiv_if.sv | 27 ++
 rtl/md_iter_step.sv | 38 +++
 rtl/ex_muldiv.sv | 171 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// func3 op codes, FSM states and operand sign helpers.
package ex_muldiv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } md_state_e;

    function automatic logic op_is_div(md_op_e op);
        return op inside {OpDiv, OpDivu, OpRem, OpRemu};
    endfunction

    function automatic logic src1_signed(md_op_e op);
        return op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
    endfunction

    function automatic logic src2_signed(md_op_e op);
        return op inside {OpMulh, OpDiv, OpRem};
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Issue/result bundle between the ex stage (master) and the mul/div unit (slave).
interface ex_muldiv_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  start_i;
    logic                  flush_i;
    logic [2:0]            op_i;
    logic [XLEN-1:0]       src1_i;
    logic [XLEN-1:0]       src2_i;
    logic [REG_ADDR_W-1:0] w_reg_addr_i;
    logic                  busy_o;
    logic                  done_o;
    logic [XLEN-1:0]       result_o;
    logic                  w_reg_enable_o;
    logic [REG_ADDR_W-1:0] w_reg_addr_o;

    modport master (
        output start_i, flush_i, op_i, src1_i, src2_i, w_reg_addr_i,
        input  busy_o, done_o, result_o, w_reg_enable_o, w_reg_addr_o
    );

    modport slave (
        input  start_i, flush_i, op_i, src1_i, src2_i, w_reg_addr_i,
        output busy_o, done_o, result_o, w_reg_enable_o, w_reg_addr_o
    );
endinterface

// File: rtl/md_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step
// on the shared {hi, lo} working pair.
module md_iter_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    logic            unused_diff;

    // A successful subtract always leaves a remainder below the divisor, so bit XLEN is zero.
    assign unused_diff = diff[XLEN];

    always_comb begin
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
        shifted = {hi_i, lo_i[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, b_i};
        if (is_div_i) begin
            if (!diff[XLEN+1]) begin
                hi_o = diff[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b1};
            end else begin
                hi_o = shifted[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: magnitude datapath, STEP_BITS iterations
// per CALC cycle, sign fix-up, and special cases short-circuited straight to DONE.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned STEP_BITS  = 1,
    parameter int unsigned REG_ADDR_W = 5
) (
    input logic        clk,
    input logic        rst_n,
    ex_muldiv_if.slave bus
);
    localparam int unsigned ITERS = XLEN / STEP_BITS;
    localparam int unsigned CNT_W = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e             state_q, state_d;
    md_op_e                op_q;
    logic                  neg1_q, neg2_q;
    logic [XLEN-1:0]       b_q, hi_q, lo_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [REG_ADDR_W-1:0] rd_q, waddr_q;
    logic [XLEN-1:0]       result_q;
    logic                  busy_q, busy_d, done_q, done_d;

    md_op_e                op_in;
    logic                  neg1_in, neg2_in, div_ovf, special;
    logic [XLEN-1:0]       abs1, abs2, special_res;

    logic [2*XLEN-1:0]     prod, prod_fix;
    logic [XLEN-1:0]       q_fix, r_fix, fix_res;

    logic                  accept;
    logic                  is_div;
    logic [XLEN-1:0]       hi_c [STEP_BITS+1];
    logic [XLEN-1:0]       lo_c [STEP_BITS+1];

    assign accept = (state_q == StIdle) && bus.start_i && !bus.flush_i;
    assign is_div = op_is_div(op_q);

    assign hi_c[0] = hi_q;
    assign lo_c[0] = lo_q;

    for (genvar g = 0; g < STEP_BITS; g++) begin : g_step
        md_iter_step #(
            .XLEN(XLEN)
        ) u_step (
            .is_div_i (is_div),
            .hi_i     (hi_c[g]),
            .lo_i     (lo_c[g]),
            .b_i      (b_q),
            .hi_o     (hi_c[g+1]),
            .lo_o     (lo_c[g+1])
        );
    end

    // Issue-side decode: magnitudes, sign flags and the short-circuit results.
    always_comb begin
        op_in   = md_op_e'(bus.op_i);
        neg1_in = src1_signed(op_in) & bus.src1_i[XLEN-1];
        neg2_in = src2_signed(op_in) & bus.src2_i[XLEN-1];
        abs1    = neg1_in ? -bus.src1_i : bus.src1_i;
        abs2    = neg2_in ? -bus.src2_i : bus.src2_i;
        div_ovf = (op_in == OpDiv || op_in == OpRem) && (bus.src1_i == MIN_VAL) &&
                  (&bus.src2_i);
        special     = 1'b0;
        special_res = '0;
        if (op_is_div(op_in)) begin
            if (bus.src2_i == '0) begin
                special     = 1'b1;
                special_res = bus.op_i[1] ? bus.src1_i : '1;
            end else if (div_ovf) begin
                special     = 1'b1;
                special_res = bus.op_i[1] ? '0 : bus.src1_i;
            end
        end else begin
            special = (bus.src1_i == '0) || (bus.src2_i == '0);
        end
    end

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = (neg1_q ^ neg2_q) ? -prod : prod;
        q_fix    = (neg1_q ^ neg2_q) ? -lo_q : lo_q;
        r_fix    = neg1_q ? -hi_q : hi_q;
        case (op_q)
            OpMul:                     fix_res = prod_fix[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: fix_res = prod_fix[2*XLEN-1:XLEN];
            OpDiv, OpDivu:             fix_res = q_fix;
            default:                   fix_res = r_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (bus.start_i) state_d = special ? StDone : StCalc;
                StCalc:  if (cnt_q == LAST_CNT) state_d = StFix;
                StFix:   state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Registered handshake outputs: busy covers CALC..DONE, done trails DONE by one edge.
    always_comb begin
        busy_d = (state_d == StCalc) || (state_d == StFix) || (state_d == StDone);
        done_d = (state_q == StDone) && !bus.flush_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OpMul;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            waddr_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            if (accept) begin
                op_q   <= op_in;
                neg1_q <= neg1_in;
                neg2_q <= neg2_in;
                rd_q   <= bus.w_reg_addr_i;
                cnt_q  <= '0;
                hi_q   <= '0;
                b_q    <= op_is_div(op_in) ? abs2 : abs1;
                lo_q   <= special ? special_res : (op_is_div(op_in) ? abs1 : abs2);
            end else if (state_q == StCalc) begin
                hi_q  <= hi_c[STEP_BITS];
                lo_q  <= lo_c[STEP_BITS];
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (state_q == StFix) begin
                lo_q <= fix_res;
            end
            if (done_d) begin
                result_q <= lo_q;
                waddr_q  <= rd_q;
            end
        end
    end

    assign bus.busy_o         = busy_q;
    assign bus.done_o         = done_q;
    assign bus.w_reg_enable_o = done_q;
    assign bus.result_o       = result_q;
    assign bus.w_reg_addr_o   = waddr_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: three XLEN=32 instances (STEP_BITS 1/2/4) and one XLEN=16 instance,
// directed and random ops checked against an arithmetic reference model.
module tb_ex_muldiv;
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    localparam int NVEC = 13;
    localparam vec_t VECS [NVEC] = '{
        '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF},
        '{3'd0, 32'd0,         32'd1234,      32'd0},
        '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD},
        '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},
        '{3'd5, 32'd100,       32'd7,         32'd14},
        '{3'd7, 32'd100,       32'd7,         32'd2},
        '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF},
        '{3'd7, 32'd5,         32'd0,         32'd5},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0}
    };

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    logic        start_v [4];
    logic        flush_v [4];
    logic [2:0]  op_v    [4];
    logic [31:0] a_v     [4];
    logic [31:0] b_v     [4];
    logic [4:0]  rd_v    [4];
    logic        busy_v  [4];
    logic        done_v  [4];
    logic        wen_v   [4];
    logic [31:0] res_v   [4];
    logic [4:0]  wa_v    [4];

    for (genvar g = 0; g < 3; g++) begin : g_w32
        ex_muldiv_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();
        ex_muldiv #(
            .XLEN(32), .STEP_BITS(1 << g), .REG_ADDR_W(5)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
        assign bus.start_i      = start_v[g];
        assign bus.flush_i      = flush_v[g];
        assign bus.op_i         = op_v[g];
        assign bus.src1_i       = a_v[g];
        assign bus.src2_i       = b_v[g];
        assign bus.w_reg_addr_i = rd_v[g];
        assign busy_v[g]        = bus.busy_o;
        assign done_v[g]        = bus.done_o;
        assign wen_v[g]         = bus.w_reg_enable_o;
        assign res_v[g]         = bus.result_o;
        assign wa_v[g]          = bus.w_reg_addr_o;
    end

    ex_muldiv_if #(.XLEN(16), .REG_ADDR_W(5)) bus16 ();
    ex_muldiv #(
        .XLEN(16), .STEP_BITS(1), .REG_ADDR_W(5)
    ) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );
    logic unused_hi;
    assign unused_hi          = ^{a_v[3][31:16], b_v[3][31:16]};
    assign bus16.start_i      = start_v[3];
    assign bus16.flush_i      = flush_v[3];
    assign bus16.op_i         = op_v[3];
    assign bus16.src1_i       = a_v[3][15:0];
    assign bus16.src2_i       = b_v[3][15:0];
    assign bus16.w_reg_addr_i = rd_v[3];
    assign busy_v[3]          = bus16.busy_o;
    assign done_v[3]          = bus16.done_o;
    assign wen_v[3]           = bus16.w_reg_enable_o;
    assign res_v[3]           = {16'h0, bus16.result_o};
    assign wa_v[3]            = bus16.w_reg_addr_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] w1(input logic x);
        return {31'b0, x};
    endfunction

    function automatic logic [31:0] w5(input logic [4:0] x);
        return {27'b0, x};
    endfunction

    function automatic int xlen_of(input int sel);
        return (sel == 3) ? 16 : 32;
    endfunction

    function automatic logic [31:0] fit(input int sel, input logic [31:0] v);
        if (sel != 3) return v;
        if (v == 32'h8000_0000) return 32'h0000_8000;
        return v & 32'h0000_FFFF;
    endfunction

    // RISC-V M semantics in plain 64-bit signed arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input int xl);
        longint m, ua, ub, sa, sb, mn, r;
        m  = (longint'(1) << xl) - 1;
        ua = longint'({32'h0, a}) & m;
        ub = longint'({32'h0, b}) & m;
        sa = (ua > (m >> 1)) ? ua - m - 1 : ua;
        sb = (ub > (m >> 1)) ? ub - m - 1 : ub;
        mn = -(m >> 1) - 1;
        case (op)
            3'd0:    r = ua * ub;
            3'd1:    r = (sa * sb) >>> xl;
            3'd2:    r = (sa * ub) >>> xl;
            3'd3:    r = (ua * ub) >> xl;
            3'd4:    r = (ub == 0) ? m : ((sa == mn && sb == -1) ? sa : sa / sb);
            3'd5:    r = (ub == 0) ? m : ua / ub;
            3'd6:    r = (ub == 0) ? ua : ((sa == mn && sb == -1) ? 0 : sa % sb);
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        r = r & m;
        return r[31:0];
    endfunction

    function automatic int ref_lat(input int sel, input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        int          xl;
        int          st;
        logic [31:0] mn;
        logic [31:0] m1;
        xl = xlen_of(sel);
        st = (sel == 3) ? 1 : (1 << sel);
        mn = (xl == 16) ? 32'h0000_8000 : 32'h8000_0000;
        m1 = (xl == 16) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        if (op[2]) begin
            if (b == 0 || (!op[0] && a == mn && b == m1)) return 1;
        end else if (a == 0 || b == 0) begin
            return 1;
        end
        return xl / st + 2;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input int sel, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        op_v[sel]    = op;
        a_v[sel]     = a;
        b_v[sel]     = b;
        rd_v[sel]    = rd;
        start_v[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[sel] = 1'b0;
    endtask

    task automatic run_op(input int sel, input logic [2:0] op, input logic [31:0] a0,
                          input logic [31:0] b0, input logic [4:0] rd, input logic use_exp,
                          input logic [31:0] exp_in, input string tag);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] er;
        int          k;
        a  = fit(sel, a0);
        b  = fit(sel, b0);
        er = use_exp ? exp_in : ref_md(op, a, b, xlen_of(sel));
        issue(sel, op, a, b, rd);
        chk($sformatf("%s/busy", tag), w1(busy_v[sel]), 32'd1);
        k = 0;
        while (!done_v[sel] && k < 200) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        chk($sformatf("%s/lat", tag), k, ref_lat(sel, op, a, b));
        chk($sformatf("%s/res", tag), res_v[sel], er);
        chk($sformatf("%s/rd", tag), w5(wa_v[sel]), w5(rd));
        chk($sformatf("%s/wen", tag), w1(wen_v[sel]), 32'd1);
        chk($sformatf("%s/nobusy", tag), w1(busy_v[sel]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("%s/pulse", tag), w1(done_v[sel]), 32'd0);
    endtask

    initial begin
        logic [31:0] prev_res;
        logic [4:0]  prev_wa;
        int          nd;
        int          k;
        for (int i = 0; i < 4; i++) begin
            start_v[i] = 1'b0;
            flush_v[i] = 1'b0;
            op_v[i]    = 3'd0;
            a_v[i]     = '0;
            b_v[i]     = '0;
            rd_v[i]    = '0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("rst%0d/busy", s), w1(busy_v[s]), 32'd0);
            chk($sformatf("rst%0d/done", s), w1(done_v[s]), 32'd0);
            chk($sformatf("rst%0d/wen", s), w1(wen_v[s]), 32'd0);
            chk($sformatf("rst%0d/res", s), res_v[s], 32'd0);
            chk($sformatf("rst%0d/wa", s), w5(wa_v[s]), 32'd0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors on every configuration; 16-bit results come from the model.
        for (int s = 0; s < 4; s++) begin
            for (int v = 0; v < NVEC; v++) begin
                run_op(s, VECS[v].op, VECS[v].a, VECS[v].b, 5'(v + 1), (s != 3), VECS[v].res,
                       $sformatf("dir%0d_%0d", s, v));
            end
        end

        // Flush in the middle of CALC.
        prev_res = res_v[0];
        prev_wa  = wa_v[0];
        issue(0, 3'd4, 32'd100, 32'd7, 5'd9);
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        flush_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush_v[0] = 1'b0;
        chk("flush/busy", w1(busy_v[0]), 32'd0);
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done_v[0]) nd++;
        end
        chk("flush/ndone", nd, 0);
        chk("flush/res", res_v[0], prev_res);
        chk("flush/wa", w5(wa_v[0]), w5(prev_wa));
        run_op(0, 3'd4, 32'd100, 32'd7, 5'd9, 1'b1, 32'd14, "reissue");

        // Flush and start together: the start is dropped.
        @(negedge clk);
        op_v[0]    = 3'd0;
        a_v[0]     = 32'd3;
        b_v[0]     = 32'd3;
        start_v[0] = 1'b1;
        flush_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        flush_v[0] = 1'b0;
        chk("flushstart/busy", w1(busy_v[0]), 32'd0);
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done_v[0]) nd++;
        end
        chk("flushstart/ndone", nd, 0);

        // start held high through a whole MUL.
        @(negedge clk);
        op_v[0]    = 3'd0;
        a_v[0]     = 32'd6;
        b_v[0]     = 32'd7;
        rd_v[0]    = 5'd3;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        nd = 0;
        k  = 0;
        while (!done_v[0] && k < 200) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        if (done_v[0]) nd++;
        start_v[0] = 1'b0;
        chk("hold/lat", k, 34);
        chk("hold/res", res_v[0], 32'd42);
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done_v[0]) nd++;
        end
        chk("hold/ndone", nd, 1);

        // Random ops on every configuration.
        for (int s = 0; s < 4; s++) begin
            for (int n = 0; n < 25; n++) begin
                run_op(s, 3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(),
                       5'($urandom_range(0, 31)), 1'b0, 32'd0, $sformatf("rnd%0d_%0d", s, n));
            end
        end

        // Reset asserted mid-DIV, between clock edges.
        run_op(0, 3'd0, 32'd6, 32'd7, 5'd3, 1'b1, 32'd42, "prerst");
        issue(0, 3'd4, 32'd100, 32'd7, 5'd11);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst/busy", w1(busy_v[0]), 32'd0);
        chk("midrst/done", w1(done_v[0]), 32'd0);
        chk("midrst/wen", w1(wen_v[0]), 32'd0);
        chk("midrst/res", res_v[0], 32'd0);
        chk("midrst/wa", w5(wa_v[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done_v[0]) nd++;
        end
        chk("midrst/ndone", nd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
